// File: rtl/medidor_pkg.sv
// medidor_pkg: shared definitions for the multichannel range-meter controller.
// Holds the FSM state encoding (the state value doubles as the db_estado
// display code) and a width helper used for parameter-sized ports.
package medidor_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL        = 4'h0,
    ST_PREPARACAO     = 4'h1,
    ST_ENVIA_MENSURAR = 4'h2,
    ST_AGUARDA_MED    = 4'h3,
    ST_ENVIA_PARTIDA  = 4'h4,
    ST_AGUARDA_TX     = 4'h5,
    ST_PROXIMO_CHAR   = 4'h6,
    ST_PROXIMO_CANAL  = 4'h7,
    ST_ESPERA         = 4'h8,
    ST_TIMEOUT        = 4'h9,
    ST_FIM            = 4'hA
  } estado_t;

  // Display code for a state; the encoding is chosen so it is the identity.
  function automatic logic [3:0] codigo_estado(input estado_t e);
    return e;
  endfunction

  // Bits needed to index n items, never less than one.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/medidor_multicanal_uc_contador_timeout.sv
// contador_timeout: measurement watchdog counter.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous active-high reset
//   zera   in  synchronous clear (priority over conta)
//   conta  in  count enable
//   fim    out high while the count equals TIMEOUT_CICLOS-1
// The count saturates at TIMEOUT_CICLOS-1 so fim stays asserted if left enabled.
module contador_timeout
  import medidor_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 2_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = largura(TIMEOUT_CICLOS);
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT_CICLOS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta && (cnt_q != LIMITE)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim = (cnt_q == LIMITE);

endmodule

// File: rtl/medidor_multicanal_uc.sv
// medidor_multicanal_uc: control unit sweeping N_CANAIS range sensors.
// For each channel it starts a measurement, waits for the result (with a
// watchdog), then transmits N_CHARS characters before moving on. Single or
// continuous sweeps are selected by modo; dropping medir aborts at once.
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   medir, modo                      run enable / sweep mode
//   pronto_medida, pronto_tx         done pulses from datapath and transmitter
//   fim_time                         inter-sweep interval elapsed
//   mensurar, partida_tx             measurement / transmit start pulses
//   canal, indice_char               current channel and character index
//   zera, zera_time, conta_time      datapath clear, timer clear, timer enable
//   erro_timeout, pronto             watchdog error / single-sweep done pulses
//   db_estado                        state code for display
module medidor_multicanal_uc
  import medidor_pkg::*;
#(
  parameter int N_CANAIS       = 4,
  parameter int N_CHARS        = 7,
  parameter int TIMEOUT_CICLOS = 2_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          medir,
  input  logic                          modo,
  input  logic                          pronto_medida,
  input  logic                          pronto_tx,
  input  logic                          fim_time,
  output logic                          mensurar,
  output logic [largura(N_CANAIS)-1:0]  canal,
  output logic [largura(N_CHARS)-1:0]   indice_char,
  output logic                          partida_tx,
  output logic                          zera,
  output logic                          zera_time,
  output logic                          conta_time,
  output logic                          erro_timeout,
  output logic                          pronto,
  output logic [3:0]                    db_estado
);

  localparam int CW = largura(N_CANAIS);
  localparam int IW = largura(N_CHARS);
  localparam logic [CW-1:0] ULTIMO_CANAL = CW'(N_CANAIS - 1);
  localparam logic [IW-1:0] ULTIMO_CHAR  = IW'(N_CHARS - 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] canal_q, canal_d;
  logic [IW-1:0] indice_q, indice_d;
  logic          pronto_q;
  logic          fim_timeout;
  logic          zera_contador;
  logic          conta_contador;

  // Watchdog restarts with every measurement and on abort.
  assign zera_contador  = (estado_q == ST_ENVIA_MENSURAR) || !medir;
  assign conta_contador = (estado_q == ST_AGUARDA_MED);

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_contador_timeout (
    .clock(clock),
    .reset(reset),
    .zera (zera_contador),
    .conta(conta_contador),
    .fim  (fim_timeout)
  );

  always_comb begin
    estado_d = estado_q;
    canal_d  = canal_q;
    indice_d = indice_q;
    if (!medir) begin
      estado_d = ST_INICIAL;
      canal_d  = '0;
      indice_d = '0;
    end else begin
      case (estado_q)
        ST_INICIAL:        estado_d = ST_PREPARACAO;
        ST_PREPARACAO:     estado_d = ST_ENVIA_MENSURAR;
        ST_ENVIA_MENSURAR: begin
          indice_d = '0;
          estado_d = ST_AGUARDA_MED;
        end
        ST_AGUARDA_MED: begin
          // A result arriving on the last allowed cycle still counts.
          if (pronto_medida) begin
            estado_d = ST_ENVIA_PARTIDA;
          end else if (fim_timeout) begin
            estado_d = ST_TIMEOUT;
          end else begin
            estado_d = ST_AGUARDA_MED;
          end
        end
        ST_ENVIA_PARTIDA:  estado_d = ST_AGUARDA_TX;
        ST_AGUARDA_TX: begin
          if (!pronto_tx) begin
            estado_d = ST_AGUARDA_TX;
          end else if (indice_q < ULTIMO_CHAR) begin
            estado_d = ST_PROXIMO_CHAR;
          end else begin
            estado_d = ST_PROXIMO_CANAL;
          end
        end
        ST_PROXIMO_CHAR: begin
          indice_d = indice_q + IW'(1);
          estado_d = ST_ENVIA_PARTIDA;
        end
        ST_PROXIMO_CANAL: begin
          if (canal_q < ULTIMO_CANAL) begin
            canal_d  = canal_q + CW'(1);
            estado_d = ST_ENVIA_MENSURAR;
          end else begin
            canal_d  = '0;
            estado_d = modo ? ST_ESPERA : ST_FIM;
          end
        end
        ST_ESPERA:         estado_d = fim_time ? ST_ENVIA_MENSURAR : ST_ESPERA;
        ST_TIMEOUT:        estado_d = ST_PROXIMO_CANAL;
        ST_FIM:            estado_d = ST_FIM;
        default:           estado_d = ST_INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= ST_INICIAL;
      canal_q  <= '0;
      indice_q <= '0;
      pronto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      canal_q  <= canal_d;
      indice_q <= indice_d;
      // fim is held for as long as medir stays high; only its first cycle pulses.
      pronto_q <= (estado_d == ST_FIM) && (estado_q != ST_FIM);
    end
  end

  always_comb begin
    mensurar     = 1'b0;
    partida_tx   = 1'b0;
    zera         = 1'b0;
    zera_time    = 1'b0;
    conta_time   = 1'b0;
    erro_timeout = 1'b0;
    case (estado_q)
      ST_PREPARACAO:     zera = 1'b1;
      ST_ENVIA_MENSURAR: begin
        mensurar  = 1'b1;
        zera_time = 1'b1;
      end
      ST_ENVIA_PARTIDA:  partida_tx   = 1'b1;
      ST_ESPERA:         conta_time   = 1'b1;
      ST_TIMEOUT:        erro_timeout = 1'b1;
      default:           mensurar     = 1'b0;
    endcase
  end

  assign canal       = canal_q;
  assign indice_char = indice_q;
  assign pronto      = pronto_q;
  assign db_estado   = codigo_estado(estado_q);

endmodule

// File: tb/tb_medidor_multicanal_uc.sv
// Bench for medidor_multicanal_uc with 2 channels, 3 characters, timeout 10.
// Expected pulse events are queued by the stimulus; a monitor pops and
// compares each observed pulse. A responder emulates datapath/transmitter.
module tb_medidor_multicanal_uc;

  localparam int NC  = 2;
  localparam int NCH = 3;
  localparam int TO  = 10;

  localparam int EV_M = 1;
  localparam int EV_P = 2;
  localparam int EV_T = 3;
  localparam int EV_F = 4;

  logic       clock;
  logic       reset;
  logic       medir;
  logic       modo;
  logic       pronto_medida;
  logic       pronto_tx;
  logic       fim_time;
  logic       mensurar;
  logic [0:0] canal;
  logic [1:0] indice_char;
  logic       partida_tx;
  logic       zera;
  logic       zera_time;
  logic       conta_time;
  logic       erro_timeout;
  logic       pronto;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;

  logic [11:0] esperado[$];

  int med_delay [NC];
  int tx_delay;

  medidor_multicanal_uc #(
    .N_CANAIS(NC),
    .N_CHARS(NCH),
    .TIMEOUT_CICLOS(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .medir(medir),
    .modo(modo),
    .pronto_medida(pronto_medida),
    .pronto_tx(pronto_tx),
    .fim_time(fim_time),
    .mensurar(mensurar),
    .canal(canal),
    .indice_char(indice_char),
    .partida_tx(partida_tx),
    .zera(zera),
    .zera_time(zera_time),
    .conta_time(conta_time),
    .erro_timeout(erro_timeout),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [11:0] ev(input int t, input int c, input int i);
    return {4'(t), 4'(c), 4'(i)};
  endfunction

  // Monitor: every pulse output must match the head of the expected queue.
  initial begin
    logic [11:0] got;
    logic [11:0] want;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
        logic hit;
        hit = 1'b0;
        got = 12'h000;
        if (k == 0 && mensurar === 1'b1) begin
          hit = 1'b1; got = ev(EV_M, int'(canal), 0);
        end
        if (k == 1 && partida_tx === 1'b1) begin
          hit = 1'b1; got = ev(EV_P, int'(canal), int'(indice_char));
        end
        if (k == 2 && erro_timeout === 1'b1) begin
          hit = 1'b1; got = ev(EV_T, int'(canal), 0);
        end
        if (k == 3 && pronto === 1'b1) begin
          hit = 1'b1; got = ev(EV_F, int'(canal), 0);
        end
        if (hit) begin
          total++;
          if (esperado.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_unexpected: got %h want none", got);
          end else begin
            want = esperado.pop_front();
            if (got !== want) begin
              bad++;
              $display("FAIL scoreboard: got %h want %h", got, want);
            end
          end
        end
      end
    end
  end

  // Responder: answers in aguarda_med / aguarda_tx after a programmable delay.
  initial begin
    int cm;
    int ct;
    cm = 0;
    ct = 0;
    pronto_medida = 1'b0;
    pronto_tx     = 1'b0;
    forever begin
      @(negedge clock);
      pronto_medida = 1'b0;
      pronto_tx     = 1'b0;
      if (db_estado == 4'h3) begin
        pronto_medida = (cm == med_delay[int'(canal)]);
        cm++;
      end else begin
        cm = 0;
      end
      if (db_estado == 4'h5) begin
        pronto_tx = (ct == tx_delay);
        ct++;
      end else begin
        ct = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic wait_estado(input logic [3:0] e, input int lim);
    int n;
    n = 0;
    while (db_estado !== e && n < lim) begin
      @(negedge clock);
      n++;
    end
    if (db_estado !== e) begin
      total++;
      bad++;
      $display("FAIL wait_estado: got %0h want %0h", db_estado, e);
    end
  endtask

  task automatic push_sweep(input int to_ch);
    for (int c = 0; c < NC; c++) begin
      esperado.push_back(ev(EV_M, c, 0));
      if (c == to_ch) begin
        esperado.push_back(ev(EV_T, c, 0));
      end else begin
        for (int i = 0; i < NCH; i++) esperado.push_back(ev(EV_P, c, i));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    reset = 1'b1; medir = 1'b0; modo = 1'b0; fim_time = 1'b0;
    med_delay[0] = 0; med_delay[1] = 0; tx_delay = 0;
    repeat (2) @(negedge clock);
    chk("reset_estado", 32'(db_estado), 32'h0);
    chk("reset_pulsos", {26'd0, mensurar, partida_tx, erro_timeout, pronto, zera, conta_time}, 32'h0);
    chk("reset_canal_idx", {29'd0, canal, indice_char}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Single sweep, immediate responses.
    push_sweep(-1);
    esperado.push_back(ev(EV_F, 0, 0));
    medir = 1'b1;
    wait_estado(4'hA, 300);
    repeat (5) @(negedge clock);
    chk("fim_hold", 32'(db_estado), 32'hA);
    chk("fim_pronto_low", 32'(pronto), 32'h0);
    chk("sweep1_queue", 32'(esperado.size()), 32'h0);
    medir = 1'b0;
    @(negedge clock);
    chk("abort_fim", 32'(db_estado), 32'h0);
    repeat (2) @(negedge clock);

    // Channel 0 never answers: watchdog fires 10 cycles into aguarda_med.
    med_delay[0] = -1;
    push_sweep(0);
    esperado.push_back(ev(EV_F, 0, 0));
    medir = 1'b1;
    wait_estado(4'h3, 50);
    n = 0;
    while (erro_timeout !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_latency", 32'(n), 32'd10);
    wait_estado(4'hA, 300);
    @(negedge clock);
    chk("timeout_queue", 32'(esperado.size()), 32'h0);
    medir = 1'b0;
    repeat (3) @(negedge clock);

    // Result arrives on the very cycle the watchdog expires.
    med_delay[0] = TO - 1;
    push_sweep(-1);
    esperado.push_back(ev(EV_F, 0, 0));
    medir = 1'b1;
    wait_estado(4'h3, 50);
    repeat (TO) @(negedge clock);
    chk("race_partida", 32'(db_estado), 32'h4);
    chk("race_no_erro", 32'(erro_timeout), 32'h0);
    wait_estado(4'hA, 300);
    @(negedge clock);
    chk("race_queue", 32'(esperado.size()), 32'h0);
    medir = 1'b0;
    repeat (3) @(negedge clock);

    // Continuous sweep, then abort while waiting on the transmitter.
    med_delay[0] = 0;
    tx_delay = 3;
    modo = 1'b1;
    push_sweep(-1);
    esperado.push_back(ev(EV_M, 0, 0));
    esperado.push_back(ev(EV_P, 0, 0));
    medir = 1'b1;
    wait_estado(4'h8, 400);
    repeat (3) begin
      @(negedge clock);
      chk("espera_conta", {27'd0, db_estado, conta_time}, {27'd0, 4'h8, 1'b1});
    end
    fim_time = 1'b1;
    @(negedge clock);
    fim_time = 1'b0;
    chk("espera_saida", {28'd0, db_estado}, 32'h2);
    wait_estado(4'h5, 50);
    medir = 1'b0;
    @(negedge clock);
    chk("abort_tx", 32'(db_estado), 32'h0);
    repeat (10) @(negedge clock);
    chk("abort_queue", 32'(esperado.size()), 32'h0);
    modo = 1'b0;

    // Reset mid-sweep on channel 1.
    esperado.push_back(ev(EV_M, 0, 0));
    for (int i = 0; i < NCH; i++) esperado.push_back(ev(EV_P, 0, i));
    esperado.push_back(ev(EV_M, 1, 0));
    esperado.push_back(ev(EV_P, 1, 0));
    medir = 1'b1;
    n = 0;
    while (!(db_estado === 4'h5 && canal === 1'b1) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("reach_ch1_tx", {28'd0, db_estado[2:0], canal}, {28'd0, 3'h5, 1'b1});
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_estado", 32'(db_estado), 32'h0);
    chk("rst_mid_canal_idx", {29'd0, canal, indice_char}, 32'h0);
    chk("rst_mid_pulsos", {26'd0, mensurar, partida_tx, erro_timeout, pronto, zera_time, conta_time}, 32'h0);
    medir = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_mid_queue", 32'(esperado.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
